// File: rtl/av2_bitstream_feeder.sv
// Purpose : packs 32-bit host bitstream words MSB-first into 128-bit words for the AV2 decoder.
// Latency : a completing input word accepted at cycle N is visible on bitstream_data at N+1 (empty FIFO).
// Backpressure: bitstream_ready low fills a FIFO_DEPTH-entry FIFO; when it is full, in_ready drops.
//
// Ports (av2_bitstream_feeder):
//   clk, rst_n                          clock, synchronous active-low reset
//   start                               begin a new tile stream (aborts any stream in progress)
//   in_data/in_valid/in_last/in_ready   32-bit host word handshake; in_last marks the tile's final word
//   bitstream_data/_valid/_ready        128-bit packed word handshake towards the decoder
//   busy, done, word_count              status: streaming/draining, end-of-tile pulse, words delivered
// Build option: define AV2_FEEDER_BYTESWAP_EN to byte-reverse every accepted in_data before packing.

// Purpose : generic show-ahead FIFO with a synchronous clear.
// Latency : a pushed entry appears at head_dat one cycle after the push.
// Backpressure: a push while full is dropped (a same-cycle pop does not make room).
module av2_feeder_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full,
  output logic         one_left
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign one_left = (count == CW'(1));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only looked at while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// Purpose : AV2 bitstream feeder (4x32 -> 128 packer + packed-word FIFO + tile control FSM).
// Latency : 1 cycle from completing input accept to bitstream_valid when the FIFO is empty.
// Backpressure: decoder stalls are absorbed by the FIFO; in_ready is low while it is full.
module av2_bitstream_feeder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [127:0] bitstream_data,
  output logic         bitstream_valid,
  input  logic         bitstream_ready,
  output logic         busy,
  output logic         done,
  output logic [15:0]  word_count
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   cnt;
  logic [31:0]  lane0;
  logic [31:0]  lane1;
  logic [31:0]  lane2;
  logic [31:0]  word_in;
  logic [127:0] pack_dat;
  logic [127:0] head_dat;
  logic         fifo_empty;
  logic         fifo_full;
  logic         fifo_one_left;
  logic         accept;
  logic         push;
  logic         pop;
  logic         final_pop;

`ifdef AV2_FEEDER_BYTESWAP_EN
  // Little-endian host words are reversed into bitstream byte order.
  assign word_in = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
  assign word_in = in_data;
`endif

  // fifo_full is the registered flag, so a pop in the same cycle never opens a slot early.
  assign in_ready        = (state == STREAM) && !fifo_full && !start;
  assign accept          = in_valid && in_ready;
  assign push            = accept && ((cnt == 2'd3) || in_last);
  assign bitstream_valid = !fifo_empty;
  assign bitstream_data  = fifo_empty ? '0 : head_dat;
  assign pop             = bitstream_valid && bitstream_ready;
  // Nothing is pushed in DRAIN, so popping the only entry there ends the tile.
  assign final_pop       = (state == DRAIN) && pop && fifo_one_left;
  assign busy            = (state != IDLE);

  // First word of a packed word lands in [127:96]; lanes below the completing word are zero.
  always_comb begin
    pack_dat = '0;
    case (cnt)
      2'd0:    pack_dat = {word_in, 96'd0};
      2'd1:    pack_dat = {lane0, word_in, 64'd0};
      2'd2:    pack_dat = {lane0, lane1, word_in, 32'd0};
      default: pack_dat = {lane0, lane1, lane2, word_in};
    endcase
  end

  av2_feeder_fifo #(
    .W     (128),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .push     (push),
    .push_dat (pack_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .one_left (fifo_one_left)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      lane0      <= '0;
      lane1      <= '0;
      lane2      <= '0;
      done       <= 1'b0;
      word_count <= '0;
    end else if (start) begin
      // Abort: partial lanes are simply forgotten by resetting cnt.
      state      <= STREAM;
      cnt        <= 2'd0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      done <= 1'b0;

      if (pop && (word_count != 16'hFFFF)) word_count <= word_count + 16'd1;

      case (state)
        STREAM: if (accept && in_last) state <= DRAIN;
        DRAIN: begin
          if (final_pop) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= state;
      endcase

      if (accept) begin
        if (push) begin
          cnt <= 2'd0;
        end else begin
          case (cnt)
            2'd0:    lane0 <= word_in;
            2'd1:    lane1 <= word_in;
            default: lane2 <= word_in;
          endcase
          cnt <= cnt + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_av2_bitstream_feeder.sv
module tb_av2_bitstream_feeder;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_STREAM = 1, M_DRAIN = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [127:0] bitstream_data;
  logic         bitstream_valid;
  logic         bitstream_ready;
  logic         busy;
  logic         done;
  logic [15:0]  word_count;

  av2_bitstream_feeder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .bitstream_data  (bitstream_data),
    .bitstream_valid (bitstream_valid),
    .bitstream_ready (bitstream_ready),
    .busy            (busy),
    .done            (done),
    .word_count      (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             m_state = M_IDLE;
  logic [127:0]   m_q[$];
  logic [31:0]    m_part[$];
  int             m_wc = 0;
  bit             m_done = 0;
  bit             m_acc, m_pop;
  logic [127:0]   m_w;

  function automatic logic [31:0] host_to_bs(input logic [31:0] d);
`ifdef AV2_FEEDER_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_state = M_IDLE; m_q.delete(); m_part.delete(); m_wc = 0; m_done = 0;
    end else if (start) begin
      m_state = M_STREAM; m_q.delete(); m_part.delete(); m_wc = 0; m_done = 0;
    end else begin
      m_acc  = in_valid && (m_state == M_STREAM) && (m_q.size() < DEPTH);
      m_pop  = (m_q.size() != 0) && bitstream_ready;
      m_done = 0;
      if (m_pop) begin
        void'(m_q.pop_front());
        if (m_wc < 65535) m_wc++;
        if (m_state == M_DRAIN && m_q.size() == 0) begin
          m_state = M_IDLE;
          m_done  = 1;
        end
      end
      if (m_acc) begin
        m_part.push_back(host_to_bs(in_data));
        if (m_part.size() == 4 || in_last) begin
          m_w = '0;
          foreach (m_part[i]) m_w[127-32*i -: 32] = m_part[i];
          m_q.push_back(m_w);
          m_part.delete();
          if (in_last) m_state = M_DRAIN;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit           chk_en = 0;
  logic [127:0] log_q[$];
  int           done_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, (m_state == M_STREAM) && (m_q.size() < DEPTH) && !start);
      check("bitstream_valid", bitstream_valid, m_q.size() != 0);
      check("bitstream_data", bitstream_data, (m_q.size() != 0) ? m_q[0] : 128'd0);
      check("busy", busy, m_state != M_IDLE);
      check("done", done, m_done);
      check("word_count", word_count, 128'(m_wc));
      if (bitstream_valid === 1'b1 && bitstream_ready === 1'b1) log_q.push_back(bitstream_data);
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] wbuf[64];
  int          first_stall;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    log_q.delete();
    done_cnt = 0;
  endtask

  // rmode: 0 ready=1, 1 random, 2 held low until 5 stalled cycles then 1, 3 ready=0
  task automatic send(input int n, input bit last, input int rmode, input bit vrand);
    int  idx = 0;
    int  stalls = 0;
    int  guard = 0;
    bit  rdy_s;
    first_stall = -1;
    while (idx < n && guard < 1000) begin
      guard++;
      in_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = wbuf[idx];
      in_last  = last && (idx == n - 1);
      case (rmode)
        0: bitstream_ready = 1'b1;
        1: bitstream_ready = $urandom_range(0, 1) == 1;
        2: bitstream_ready = (stalls >= 5);
        default: bitstream_ready = 1'b0;
      endcase
      @(negedge clk);
      rdy_s = in_ready;
      if (in_valid && !rdy_s && rmode == 2) begin
        if (first_stall < 0) first_stall = idx;
        stalls++;
      end
      tick();
      if (in_valid && rdy_s) idx++;
    end
    if (idx < n) check("send_timeout", idx, n);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input bit rrand);
    int guard = 0;
    while (done_cnt == 0 && guard < 300) begin
      bitstream_ready = rrand ? ($urandom_range(0, 1) == 1) : 1'b1;
      tick();
      guard++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    bitstream_ready = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    bitstream_ready = 1'b0;

    // Reset with random inputs
    tick();
    chk_en = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom; in_valid = $urandom_range(0, 1) == 1;
      in_last = $urandom_range(0, 1) == 1; start = $urandom_range(0, 1) == 1;
      bitstream_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_valid", bitstream_valid, 0);
    check("reset_data", bitstream_data, 0);
    check("reset_word_count", word_count, 0);
    check("reset_busy", busy, 0);
    tick();
    in_valid = 1'b0;

    // Full word
    do_start();
    wbuf[0] = 32'h11111111; wbuf[1] = 32'h22222222; wbuf[2] = 32'h33333333; wbuf[3] = 32'h44444444;
    send(4, 1, 0, 0);
    wait_done(0);
    check("full_nwords", log_q.size(), 1);
    if (log_q.size() >= 1) check("full_word", log_q[0], 128'h11111111_22222222_33333333_44444444);
    check("full_done_pulses", done_cnt, 1);
    check("full_word_count", word_count, 1);

    // Partial tail
    do_start();
    for (int i = 0; i < 6; i++) wbuf[i] = {4{8'(8'h11 * (i + 1))}};
    send(6, 1, 0, 0);
    wait_done(0);
    check("tail_nwords", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      check("tail_word1", log_q[0], 128'h11111111_22222222_33333333_44444444);
      check("tail_word2", log_q[1], 128'h55555555_66666666_00000000_00000000);
    end
    check("tail_done_pulses", done_cnt, 1);
    check("tail_word_count", word_count, 2);

    // Back-pressure
    do_start();
    for (int i = 0; i < 20; i++) wbuf[i] = $urandom;
    send(20, 1, 2, 0);
    check("bp_first_stall", first_stall, 16);
    wait_done(0);
    check("bp_nwords", log_q.size(), 5);
    check("bp_word_count", word_count, 5);

    // Abort with 2 words queued and 2 lanes held
    do_start();
    for (int i = 0; i < 14; i++) wbuf[i] = $urandom;
    send(4, 0, 0, 0);
    tick();
    bitstream_ready = 1'b0;
    @(negedge clk);
    check("abort_pre_count", word_count, 1);
    tick();
    for (int i = 0; i < 10; i++) wbuf[i] = wbuf[i + 4];
    send(10, 0, 3, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("abort_valid", bitstream_valid, 0);
    check("abort_word_count", word_count, 0);
    log_q.delete(); done_cnt = 0;
    tick();
    wbuf[0] = 32'hAAAAAAAA; wbuf[1] = 32'hBBBBBBBB; wbuf[2] = 32'hCCCCCCCC; wbuf[3] = 32'hDDDDDDDD;
    send(4, 1, 0, 0);
    wait_done(0);
    check("abort_nwords", log_q.size(), 1);
    if (log_q.size() >= 1) check("abort_new_word", log_q[0], 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);

`ifdef AV2_FEEDER_BYTESWAP_EN
    do_start();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h11223344;
    send(4, 1, 0, 0);
    wait_done(0);
    check("swap_nwords", log_q.size(), 1);
    if (log_q.size() >= 1) check("swap_word", log_q[0], 128'h44332211_44332211_44332211_44332211);
`endif

    // Randomized streams, random handshakes, occasional abort or reset
    for (int it = 0; it < 40; it++) begin
      do_start();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      if (it == 20) begin
        send(n, 0, 1, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
      end else if ($urandom_range(0, 4) == 0) begin
        send(n, 0, 1, 1);
      end else begin
        send(n, 1, 1, 1);
        wait_done(1);
        check("rand_nwords", log_q.size(), (n + 3) / 4);
        check("rand_done_pulses", done_cnt, 1);
      end
    end

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/av2_bitstream_feeder.md
# av2_bitstream_feeder

Transmit-side source for the AV2 entropy decoder's 128-bit bitstream port. Accepts 32-bit bitstream words from the host/DMA side, packs four of them MSB-first into 128-bit words, and buffers the packed words in a small FIFO. Drives `bitstream_data`/`bitstream_valid` and honours `bitstream_ready`, so the decoder sees back-pressured, in-order packed words. Tail words shorter than 128 bits are zero-padded on `in_last`.

## Interface
- `FIFO_DEPTH`, 4: packed-word FIFO entries; power of two, ≥2.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  begins a new tile stream. Clears the packer, FIFO and `word_count`. Aborts any stream in progress.
- `in_data`  in  32  host bitstream word.
- `in_valid`  in  1  `in_data` valid.
- `in_last`  in  1  qualifies `in_data` as the final word of the tile.
- `in_ready`  out  1  feeder accepts `in_data` this cycle.
- `bitstream_data`  out  128  packed word to the decoder.
- `bitstream_valid`  out  1  `bitstream_data` valid.
- `bitstream_ready`  in  1  decoder accepts the word.
- `busy`  out  1  high in STREAM or DRAIN.
- `done`  out  1  one-cycle pulse after the final packed word is accepted.
- `word_count`  out  16  packed words handed to the decoder since `start`; saturates at 16'hFFFF.

## Operation
- **States:**
  - IDLE: `in_ready`=0. `start` → STREAM.
  - STREAM: accepts input. An accepted `in_last` → DRAIN.
  - DRAIN: `in_ready`=0. Final pop → IDLE, with `done`=1 in the next cycle.
- **Abort:** `start` in any state clears everything and goes to STREAM.
- **`in_ready`:** equals (state==STREAM) && !fifo_full && !start. Input accept = `in_valid` && `in_ready`.
- **Packer:**
  - 2-bit lane counter `cnt` and three 32-bit lane registers.
  - On accept with `cnt` < 3 and !`in_last`: store to lane `cnt`, then `cnt`++.
  - On accept with `cnt`==3 or `in_last`: push {held lanes, `in_data`, zero lanes} into the FIFO in the same cycle, then `cnt`←0.
  - The first word of a packed word occupies bits [127:96]. Unused lower lanes are zero.
- **FIFO:**
  - Show-ahead. `bitstream_data` is the head entry; `bitstream_valid` = !fifo_empty.
  - Pop = `bitstream_valid` && `bitstream_ready`.
  - Push and pop in the same cycle are both honoured (count unchanged).
  - No push while full, even when a pop happens that cycle. `in_ready` uses the registered full flag.
- **`word_count`:** increments on every pop, saturates at 16'hFFFF, and is cleared by `start`.
- **`busy`:** high when state is STREAM or DRAIN.
- **Empty stream:** if no `in_last` arrives, the feeder stays in STREAM indefinitely. Partial lanes are held and never emitted.

## Timing
- Reset values: `in_ready`=0, `bitstream_valid`=0, `bitstream_data`=0, `busy`=0, `done`=0, `word_count`=0, state IDLE, FIFO empty, `cnt`=0.
- `start` sampled at cycle N: state is STREAM at N+1 and `in_ready` may be high at N+1. A pending FIFO head is dropped; `bitstream_valid`=0 at N+1.
- Latency: a completing input word accepted at N gives `bitstream_valid`=1 at N+1, when the FIFO was empty.
- Throughput: one 32-bit input per cycle, one packed word out per 4 inputs. The FIFO absorbs decoder stalls up to `FIFO_DEPTH` words.
- Final pop at N: `done`=1 at N+1 only, state IDLE at N+1, `busy`=0 at N+1.
- `rst_n` low mid-stream: all state returns to reset values at the next edge. FIFO contents are discarded.
- `bitstream_data` stays stable while `bitstream_valid`=1 and `bitstream_ready`=0.

## Configuration
- `AV2_FEEDER_BYTESWAP_EN` defined: each accepted `in_data` is byte-reversed before packing (little-endian host to bitstream order). Example: 32'h11223344 is packed as 32'h44332211.
- Undefined: `in_data` is packed unchanged.
- Handshake and timing are identical in both builds.

## Test plan
- **Reset.** Hold `rst_n`=0 for 3 cycles with random inputs → all outputs at reset values. `in_ready`=0 until `start`.
- **Full word.** `start`, then 32'h11111111, 22222222, 33333333, 44444444 back-to-back, `in_last` on the 4th, `bitstream_ready`=1 → expect:
  - one word 128'h11111111_22222222_33333333_44444444, valid in the cycle after the 4th accept;
  - `done` pulse one cycle after the handshake;
  - `word_count`=1.
- **Partial tail.** `start`, six words 0x1..0x6 (each replicated to 32 bits), `in_last` on the 6th → expect two words:
  - word 1: 128'h11111111_22222222_33333333_44444444;
  - word 2: 128'h55555555_66666666_00000000_00000000;
  - `word_count`=2, one `done` pulse.
- **Back-pressure.** `bitstream_ready`=0, stream 20 words (`FIFO_DEPTH`=4) → `in_ready` falls after the 16th accept and `bitstream_data` stays stable. Then `bitstream_ready`=1 → all 5 words emerge in order with no loss or duplication.
- **Abort.** `start` pulsed while 2 words sit in the FIFO and `cnt`=2 → `bitstream_valid`=0 and `word_count`=0 next cycle. A following 4-word stream emits only the new data.
- **Byte swap** (`AV2_FEEDER_BYTESWAP_EN` defined). Input 32'h11223344 ×4 with `in_last` → output 128'h44332211_44332211_44332211_44332211.
